// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: drives PC hold and the
// pause/bubble controls of IF/ID, ID/EX, EX/MEM, MEM/WB, with a memory-wait timeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             fetch_valid,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_pause,
    output logic             if_id_pause,
    output logic             if_id_bubble,
    output logic             id_ex_pause,
    output logic             id_ex_bubble,
    output logic             ex_mem_pause,
    output logic             ex_mem_bubble,
    output logic             mem_wb_pause,
    output logic             mem_wb_bubble,
    output logic [1:0]       state,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              memstall, loaduse, redirect_apply;

    assign memstall = mem_req & ~mem_ready;
    assign loaduse  = ex_is_load & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

    // Controls in priority order; reset and FAULT freeze every register.
    always_comb begin
        pc_pause       = 1'b0;
        if_id_pause    = 1'b0;
        if_id_bubble   = 1'b0;
        id_ex_pause    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_pause   = 1'b0;
        ex_mem_bubble  = 1'b0;
        mem_wb_pause   = 1'b0;
        mem_wb_bubble  = 1'b0;
        redirect_apply = 1'b0;
        if (!resetn || state_q == FAULT) begin
            pc_pause     = 1'b1;
            if_id_pause  = 1'b1;
            id_ex_pause  = 1'b1;
            ex_mem_pause = 1'b1;
            mem_wb_pause = 1'b1;
        end else if (memstall) begin
            pc_pause      = 1'b1;
            if_id_pause   = 1'b1;
            id_ex_pause   = 1'b1;
            ex_mem_pause  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            if_id_bubble   = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_apply = 1'b1;
        end else if (loaduse) begin
            pc_pause     = 1'b1;
            if_id_pause  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (!fetch_valid) begin
            pc_pause     = 1'b1;
            if_id_bubble = 1'b1;
        end
    end

    // wait_cnt holds the number of consecutive stalled cycles already closed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q != FAULT) begin
            if (memstall) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                state_d    = (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) ? FAULT : MEM_WAIT;
            end else begin
                wait_cnt_d = '0;
                state_d    = RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q != FAULT) begin
                if (pc_pause && stall_cycles != '1)
                    stall_cycles <= stall_cycles + 1'b1;
                if (redirect_apply && flush_count != '1)
                    flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign mem_fault = (state_q == FAULT);

endmodule
